soc_bus_responder: RTL

Memory-side responder for the processor's single-master bus (addr / rstrb / rdata / wmask / wdata). It decodes each access into one of two regions:
- a word-organised program/data RAM with byte-lane writes;
- an IO page holding an LED register, a UART transmitter with status, and a free-running cycle counter.

It sits at the SoC top between the processor and the board pins.

---
 rtl/soc_pkg.sv | 20 ++
 rtl/uart_tx.sv | 100 ++++++++++
 rtl/soc_bus_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared constants for the SoC bus responder: IO word offsets, status bit
// positions and the UART transmitter state encoding.
package soc_pkg;

  localparam logic [1:0] IO_LEDS        = 2'd0;
  localparam logic [1:0] IO_UART_DATA   = 2'd1;
  localparam logic [1:0] IO_UART_STATUS = 2'd2;
  localparam logic [1:0] IO_CYCLE       = 2'd3;

  localparam int unsigned STAT_FULL = 0;
  localparam int unsigned STAT_OVF  = 1;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, one bit every CLK_FREQ_HZ/BAUD cycles.
// Output is registered; tx_o drops on the edge that accepts a byte.
module uart_tx
  import soc_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      UART_IDLE: begin
        if (valid_i) begin
          state_d = UART_START;
          cnt_d   = '0;
          shift_d = data_i;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (cnt_q == DIV_LAST) begin
          state_d = UART_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shift register presents the next bit at position 0.
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = UART_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        tx_d = 1'b1;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy_o = (state_q != UART_IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/soc_bus_responder.sv
// Memory-side bus responder: byte-lane RAM plus an IO page (LEDs, UART, cycle
// counter). Define SOC_UART_FIFO_EN to put a 4-entry FIFO before the UART.
module soc_bus_responder
  import soc_pkg::*;
#(
  parameter int unsigned RAM_WORDS     = 1536,
  parameter string       RAM_INIT_FILE = "firmware.hex",
  parameter int unsigned IO_BIT        = 22,
  parameter int unsigned CLK_FREQ_HZ   = 12000000,
  parameter int unsigned BAUD          = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_rstrb_i,
  output logic [31:0] mem_rdata_o,
  input  logic [3:0]  mem_wmask_i,
  input  logic [31:0] mem_wdata_i,
  output logic [4:0]  leds_o,
  output logic        uart_tx_o
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned IW     = IO_BIT - 2;

  logic [31:0] ram_q [RAM_WORDS];

  logic              io_sel, wr, ram_hit;
  logic [IW-1:0]     ram_idx;
  logic [RAM_AW-1:0] ram_addr;
  logic [1:0]        io_off;
  logic              addr_unused;

  assign io_sel      = mem_addr_i[IO_BIT];
  assign ram_idx     = mem_addr_i[IO_BIT-1:2];
  assign ram_addr    = ram_idx[RAM_AW-1:0];
  assign ram_hit     = !io_sel && (32'(ram_idx) < RAM_WORDS);
  assign io_off      = mem_addr_i[3:2];
  assign wr          = |mem_wmask_i;
  assign addr_unused = ^{mem_addr_i[31:IO_BIT+1], mem_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (wr && ram_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wmask_i[i]) ram_q[ram_addr][8*i +: 8] <= mem_wdata_i[8*i +: 8];
      end
    end
  end

  logic [4:0]  leds_q, leds_d;
  logic        ovf_q, ovf_d;
  logic [31:0] cycle_q, cycle_d;
  logic        uart_wr, stat_rd, uart_full, ovf_set;
  logic        tx_busy, tx_valid;
  logic [7:0]  tx_data;

  assign uart_wr = wr && io_sel && (io_off == IO_UART_DATA);
  assign stat_rd = mem_rstrb_i && io_sel && (io_off == IO_UART_STATUS);
  assign ovf_set = uart_wr && uart_full;

`ifdef SOC_UART_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic       fifo_empty, push, pop;

  // Pointers carry a wrap bit so equal low bits distinguish empty from full.
  assign fifo_empty = (wptr_q == rptr_q);
  assign uart_full  = (wptr_q[1:0] == rptr_q[1:0]) && (wptr_q[2] != rptr_q[2]);
  assign push       = uart_wr && !uart_full;
  assign pop        = !tx_busy && !fifo_empty;
  assign tx_valid   = pop;
  assign tx_data    = fifo_q[rptr_q[1:0]];

  always_comb begin
    wptr_d = wptr_q + 3'(push);
    rptr_d = rptr_q + 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[1:0]] <= mem_wdata_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`else
  assign uart_full = tx_busy;
  assign tx_valid  = uart_wr && !tx_busy;
  assign tx_data   = mem_wdata_i[7:0];
`endif

  always_comb begin
    leds_d  = leds_q;
    ovf_d   = ovf_q;
    cycle_d = cycle_q + 32'd1;
    if (wr && io_sel && (io_off == IO_LEDS)) leds_d = mem_wdata_i[4:0];
    // A drop on the same edge as a status read must leave the flag set.
    if (stat_rd) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q  <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      leds_q  <= leds_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  always_comb begin
    mem_rdata_o = '0;
    if (!io_sel) begin
      if (ram_hit) mem_rdata_o = ram_q[ram_addr];
    end else begin
      case (io_off)
        IO_LEDS: mem_rdata_o = {27'b0, leds_q};
        IO_UART_STATUS: begin
          mem_rdata_o[STAT_FULL] = uart_full;
          mem_rdata_o[STAT_OVF]  = ovf_q;
        end
        IO_CYCLE: mem_rdata_o = cycle_q;
        default: mem_rdata_o = '0;
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .data_i (tx_data),
    .valid_i(tx_valid),
    .busy_o (tx_busy),
    .tx_o   (uart_tx_o)
  );

  assign leds_o = leds_q;

endmodule
